// File: rtl/apb_bus_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS on the bus, one-cycle response out.
// Optional ACCESS-phase timeout is compiled in when APB_MASTER_TIMEOUT_EN is defined.
module apb_bus_master #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_id,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        sel,
    output logic              enable,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state, state_next;
    logic   accept;
    logic   done_ok;
    logic   timed_out;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..255");
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;

    // Abort on the ACCESS cycle that would bring the stall count to TIMEOUT_CYCLES.
    assign timed_out = (state == ACCESS) && !ready && (wait_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset || state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    assign accept  = (state == IDLE) && cmd_valid && cmd_ready;
    assign done_ok = (state == ACCESS) && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (cmd_id == 2'd0) ? RESP : SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (done_ok || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so cmd_ready stays low through the reset cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ready <= 1'b0;
            sel       <= '0;
            enable    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            write     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
        end else begin
            cmd_ready <= (state_next == IDLE);
            enable    <= (state_next == ACCESS);
            rsp_valid <= (state_next == RESP);

            if (state_next == SETUP) begin
                sel <= cmd_id;
            end else if (state_next != ACCESS) begin
                sel <= '0;
            end

            if (accept) begin
                write <= cmd_write;
                addr  <= cmd_addr;
                wdata <= cmd_wdata;
            end

            if (accept && cmd_id == 2'd0) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end else if (done_ok) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= write ? '0 : rdata;
            end else if (timed_out) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule
